// File: rtl/mmu_pkg.sv
// Shared types for the cache-master memory endpoint.
//   id_t    : request/response identifier, ID_NONE marks an idle slot
//   blk_t   : default-size block as a byte array
//   sel_e   : per-cycle response source chosen by the responder
package mmu_pkg;

  localparam int unsigned BLK_BYTES = 64;

  typedef logic [7:0]                 id_t;
  typedef logic [BLK_BYTES-1:0][7:0]  blk_t;

  localparam id_t ID_NONE = 8'h00;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_COMPLETE,
    SEL_DUP,
    SEL_IMM,
    SEL_ACCEPT
  } sel_e;

endpackage

// File: rtl/mem_responder_if.sv
// Cache master bus between a requester (master) and a memory endpoint (slave).
//   rqst/strb/addr/wdat : request ID (0 = idle), byte strobes, address, write data
//   resp/miss/rdat      : response ID (0 = none), deferred handle, block data
interface mem_responder_if
  import mmu_pkg::*;
#(
  parameter int unsigned BLK = 64
);

  id_t                  rqst;
  logic [BLK-1:0]       strb;
  logic [63:0]          addr;
  logic [BLK-1:0][7:0]  wdat;
  id_t                  resp;
  id_t                  miss;
  logic [BLK-1:0][7:0]  rdat;

  modport master (output rqst, strb, addr, wdat, input resp, miss, rdat);
  modport slave  (input rqst, strb, addr, wdat, output resp, miss, rdat);

endinterface

// File: rtl/mem_responder_resp_queue.sv
// FIFO of deferred responses {ID, block snapshot, latency counter}.
//   push/push_*   : enqueue at tail (ignored when full)
//   pop           : drop head (ignored when empty)
//   head_*        : view of the oldest entry, head_vld when non-empty
//   count         : number of valid entries
//   probe_id/match: per-slot hit of probe_id against valid entries
// Every valid entry's counter decrements each cycle and saturates at 0.
module resp_queue
  import mmu_pkg::*;
#(
  parameter int unsigned BLK = 64,
  parameter int unsigned QSZ = 4,
  parameter int unsigned CW  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  id_t                        push_id,
  input  logic [BLK-1:0][7:0]        push_data,
  input  logic [CW-1:0]              push_cnt,
  input  logic                       pop,
  output id_t                        head_id,
  output logic [BLK-1:0][7:0]        head_data,
  output logic [CW-1:0]              head_cnt,
  output logic                       head_vld,
  output logic [$clog2(QSZ+1)-1:0]   count,
  input  id_t                        probe_id,
  output logic [QSZ-1:0]             match
);

  localparam int unsigned PW = $clog2(QSZ);
  localparam int unsigned NW = $clog2(QSZ+1);

  id_t                 id_q   [QSZ];
  id_t                 id_d   [QSZ];
  logic [BLK-1:0][7:0] data_q [QSZ];
  logic [BLK-1:0][7:0] data_d [QSZ];
  logic [CW-1:0]       cnt_q  [QSZ];
  logic [CW-1:0]       cnt_d  [QSZ];
  logic [QSZ-1:0]      vld_q, vld_d;
  logic [PW-1:0]       wr_q, wr_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic [NW-1:0]       n_q, n_d;
  logic                push_ok, pop_ok;

  assign push_ok = push && (n_q < NW'(QSZ));
  assign pop_ok  = pop && (n_q != '0);

  always_comb begin
    id_d   = id_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    for (int unsigned i = 0; i < QSZ; i++) begin
      if (vld_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - 1'b1;
    end
    if (pop_ok) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + 1'b1;
    end
    if (push_ok) begin
      id_d[wr_q]   = push_id;
      data_d[wr_q] = push_data;
      cnt_d[wr_q]  = push_cnt;
      vld_d[wr_q]  = 1'b1;
      wr_d         = wr_q + 1'b1;
    end
    n_d = n_q + NW'(push_ok) - NW'(pop_ok);
  end

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < QSZ; i++) begin
      match[i] = vld_q[i] && (id_q[i] == probe_id);
    end
  end

  assign head_id   = id_q[rd_q];
  assign head_data = data_q[rd_q];
  assign head_cnt  = cnt_q[rd_q];
  assign head_vld  = (n_q != '0);
  assign count     = n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < QSZ; i++) begin
        id_q[i]  <= ID_NONE;
        cnt_q[i] <= '0;
      end
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      n_q   <= '0;
    end else begin
      id_q  <= id_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      n_q   <= n_d;
    end
  end

  // Payload needs no reset: slots are qualified by vld_q.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/mem_responder.sv
// Block-granular memory endpoint with fixed, programmable response latency.
//   clk, rst : clock, synchronous active-high reset
//   s        : slave side of the cache master bus
// lat==1 answers with data on the cycle after sampling; lat>=2 miss-acks
// and later completes from a FIFO in acceptance order. Writes land in the
// store at acceptance and the response carries the post-merge block.
// All outputs are registered; the store itself is never cleared.
module mem_responder
  import mmu_pkg::*;
#(
  parameter int unsigned blk   = 64,
  parameter int unsigned depth = 1024,
  parameter int unsigned lat   = 4,
  parameter int unsigned qsz   = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  s
);

  localparam int unsigned OFFS = $clog2(blk);
  localparam int unsigned IW   = $clog2(depth);
  localparam int unsigned CW   = $clog2(lat + 1);
  localparam int unsigned NW   = $clog2(qsz + 1);
  localparam logic [CW-1:0] LOAD = CW'(lat >= 2 ? lat - 2 : 0);

  typedef logic [blk-1:0][7:0] line_t;

  line_t            store_q [depth];
  line_t            merged;
  logic [IW-1:0]    idx;
  logic             st_we;

  id_t              resp_q, resp_d;
  id_t              miss_q, miss_d;
  line_t            rdat_q, rdat_d;
  sel_e             sel;

  logic             q_push, q_pop, q_head_vld;
  id_t              q_head_id;
  line_t            q_head_data;
  logic [CW-1:0]    q_head_cnt;
  logic [NW-1:0]    q_count;
  logic [qsz-1:0]   q_match;

  resp_queue #(
    .BLK (blk),
    .QSZ (qsz),
    .CW  (CW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_id   (s.rqst),
    .push_data (merged),
    .push_cnt  (LOAD),
    .pop       (q_pop),
    .head_id   (q_head_id),
    .head_data (q_head_data),
    .head_cnt  (q_head_cnt),
    .head_vld  (q_head_vld),
    .count     (q_count),
    .probe_id  (s.rqst),
    .match     (q_match)
  );

  assign idx = IW'((s.addr >> OFFS) % 64'(depth));

  always_comb begin
    merged = store_q[idx];
    for (int unsigned b = 0; b < blk; b++) begin
      if (s.strb[b]) merged[b] = s.wdat[b];
    end
  end

  // A due completion owns the output port; the request waits a cycle.
  always_comb begin
    sel = SEL_IDLE;
    if (q_head_vld && (q_head_cnt == '0))              sel = SEL_COMPLETE;
    else if ((s.rqst == ID_NONE) || (s.rqst == resp_q)) sel = SEL_IDLE;
    else if (|q_match)                                  sel = SEL_DUP;
    else if (lat == 1)                                  sel = SEL_IMM;
    else if (q_count < NW'(qsz))                        sel = SEL_ACCEPT;
  end

  always_comb begin
    resp_d = ID_NONE;
    miss_d = ID_NONE;
    rdat_d = '0;
    q_push = 1'b0;
    q_pop  = 1'b0;
    st_we  = 1'b0;
    case (sel)
      SEL_COMPLETE: begin
        resp_d = q_head_id;
        rdat_d = q_head_data;
        q_pop  = 1'b1;
      end
      SEL_DUP: begin
        resp_d = s.rqst;
        miss_d = s.rqst;
      end
      SEL_IMM: begin
        resp_d = s.rqst;
        rdat_d = merged;
        st_we  = 1'b1;
      end
      SEL_ACCEPT: begin
        resp_d = s.rqst;
        miss_d = s.rqst;
        q_push = 1'b1;
        st_we  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= ID_NONE;
      miss_q <= ID_NONE;
      rdat_q <= '0;
    end else begin
      resp_q <= resp_d;
      miss_q <= miss_d;
      rdat_q <= rdat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (st_we && !rst) store_q[idx] <= merged;
  end

  assign s.resp = resp_q;
  assign s.miss = miss_q;
  assign s.rdat = rdat_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mmu_pkg::*;

  localparam int unsigned BLK = 16;
  localparam int unsigned DEP = 64;

  typedef logic [BLK*8-1:0] bv_t;
  typedef logic [BLK-1:0]   sb_t;
  typedef struct packed { id_t resp; id_t miss; bv_t rdat; } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.BLK(BLK)) i1 (), i3 (), i4 (), i8 ();

  mem_responder #(.blk(BLK), .depth(DEP), .lat(1), .qsz(4)) u1 (.clk(clk), .rst(rst), .s(i1));
  mem_responder #(.blk(BLK), .depth(DEP), .lat(3), .qsz(4)) u3 (.clk(clk), .rst(rst), .s(i3));
  mem_responder #(.blk(BLK), .depth(DEP), .lat(4), .qsz(4)) u4 (.clk(clk), .rst(rst), .s(i4));
  mem_responder #(.blk(BLK), .depth(DEP), .lat(8), .qsz(4)) u8 (.clk(clk), .rst(rst), .s(i8));

  task automatic put(input int d, input id_t id, input sb_t st, input logic [63:0] ad, input bv_t wd);
    case (d)
      1:       begin i1.rqst = id; i1.strb = st; i1.addr = ad; i1.wdat = wd; end
      3:       begin i3.rqst = id; i3.strb = st; i3.addr = ad; i3.wdat = wd; end
      4:       begin i4.rqst = id; i4.strb = st; i4.addr = ad; i4.wdat = wd; end
      default: begin i8.rqst = id; i8.strb = st; i8.addr = ad; i8.wdat = wd; end
    endcase
  endtask

  task automatic idle(input int d);
    put(d, ID_NONE, '0, '0, '0);
  endtask

  function automatic obs_t get(input int d);
    obs_t o;
    case (d)
      1:       o = {i1.resp, i1.miss, i1.rdat};
      3:       o = {i3.resp, i3.miss, i3.rdat};
      4:       o = {i4.resp, i4.miss, i4.rdat};
      default: o = {i8.resp, i8.miss, i8.rdat};
    endcase
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input bv_t got, input bv_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response with given resp/miss IDs (ack or idle).
  task automatic expa(input int d, input string tag, input id_t r, input id_t m);
    obs_t o;
    o = get(d);
    chk({tag, ".resp"}, bv_t'(o.resp), bv_t'(r));
    chk({tag, ".miss"}, bv_t'(o.miss), bv_t'(m));
  endtask

  // Data response: resp=r, miss=0, full block compared.
  task automatic expd(input int d, input string tag, input id_t r, input bv_t dat);
    obs_t o;
    o = get(d);
    chk({tag, ".resp"}, bv_t'(o.resp), bv_t'(r));
    chk({tag, ".miss"}, bv_t'(o.miss), '0);
    chk({tag, ".rdat"}, o.rdat, dat);
  endtask

  function automatic bv_t rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bv_t bmask(input sb_t st);
    bv_t m;
    m = '0;
    for (int b = 0; b < BLK; b++) if (st[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic bv_t merge(input bv_t old, input sb_t st, input bv_t nw);
    return (old & ~bmask(st)) | (nw & bmask(st));
  endfunction

  // Transaction-level model: a requester issuing random reads/writes, a
  // byte-accurate memory image (with known-byte mask) and an in-order
  // completion scoreboard.
  task automatic rnd(input int d, input int lat, input int n);
    logic [63:0] pool [6];
    bv_t   mdat [DEP];
    bv_t   mkn  [DEP];
    id_t   eid  [$];
    bv_t   edat [$];
    bv_t   emsk [$];
    int    ecyc [$];
    int    issued, cyc, idx;
    id_t   cur;
    sb_t   cst;
    logic [63:0] cad;
    bv_t   cwd, m, msk;
    obs_t  o;
    for (int i = 0; i < 6; i++) pool[i] = {$urandom(), $urandom()};
    for (int i = 0; i < DEP; i++) begin mdat[i] = '0; mkn[i] = '0; end
    issued = 0; cyc = 0; cur = ID_NONE; cst = '0; cad = '0; cwd = '0;
    idle(d);
    while ((issued < n || eid.size() != 0 || cur != ID_NONE) && cyc < 3000) begin
      if (cur == ID_NONE && issued < n && $urandom_range(3) != 0) begin
        cur = id_t'(8'h60 + issued);
        cst = ($urandom_range(1) == 0) ? '0 : sb_t'($urandom());
        cad = pool[$urandom_range(5)];
        cwd = rnd_blk();
        put(d, cur, cst, cad, cwd);
      end
      step();
      cyc++;
      o = get(d);
      if (o.resp != ID_NONE) begin
        if (o.miss == ID_NONE) begin
          if (eid.size() == 0) begin
            chk("rnd.spurious", bv_t'(o.resp), '0);
          end else begin
            chk("rnd.order", bv_t'(o.resp), bv_t'(eid[0]));
            msk = emsk[0];
            chk("rnd.data", o.rdat & msk, edat[0] & msk);
            chk("rnd.lat_min", bv_t'(cyc - ecyc[0] >= lat - 1), bv_t'(1));
            void'(eid.pop_front()); void'(edat.pop_front());
            void'(emsk.pop_front()); void'(ecyc.pop_front());
          end
        end else if (o.miss == o.resp && o.resp == cur) begin
          idx = int'((cad >> $clog2(BLK)) % 64'(DEP));
          m = merge(mdat[idx], cst, cwd);
          mdat[idx] = m;
          mkn[idx] = mkn[idx] | bmask(cst);
          eid.push_back(cur); edat.push_back(m);
          emsk.push_back(mkn[idx]); ecyc.push_back(cyc);
          issued++;
          cur = ID_NONE;
          idle(d);
        end else begin
          chk("rnd.unexpected", bv_t'({o.resp, o.miss}), bv_t'({cur, cur}));
        end
      end
    end
    chk("rnd.drained", bv_t'(issued == n && eid.size() == 0), bv_t'(1));
    idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bv_t  wd11, wd30, wd40, wd41, ex;
    bv_t  wb [5];
    sb_t  st41;
    obs_t o;

    // Reset state
    rst = 1'b1;
    idle(1); idle(3); idle(4); idle(8);
    step(); step();
    expd(1, "rst.d1", ID_NONE, '0);
    expd(3, "rst.d3", ID_NONE, '0);
    expd(4, "rst.d4", ID_NONE, '0);
    expd(8, "rst.d8", ID_NONE, '0);
    rst = 1'b0;

    // Immediate data, lat=1
    put(1, 8'h05, sb_t'(1), 64'h1000, bv_t'(8'hAA));
    step(); expa(1, "imm.wr", 8'h05, ID_NONE);
    put(1, 8'h06, '0, 64'h1000, '0);
    step(); expa(1, "imm.rd", 8'h06, ID_NONE);
    o = get(1);
    chk("imm.rd.byte0", bv_t'(o.rdat[7:0]), bv_t'(8'hAA));
    idle(1);
    step(); expa(1, "imm.idle", ID_NONE, ID_NONE);

    // Deferred with held request, lat=4
    wd11 = rnd_blk();
    put(4, 8'h11, '1, 64'h2000, wd11);
    step(); expa(4, "held.c1", 8'h11, 8'h11);
    step(); expa(4, "held.c2_echo", ID_NONE, ID_NONE);
    step(); expa(4, "held.c3_reack", 8'h11, 8'h11);
    step(); expd(4, "held.c4_data", 8'h11, wd11);
    idle(4);
    for (int c = 0; c < 6; c++) begin
      step(); expa(4, "held.after", ID_NONE, ID_NONE);
    end

    // Completion coincides with a new request
    wd30 = rnd_blk();
    put(4, 8'h30, '1, 64'h3000, wd30);
    step(); expa(4, "cvn.ack30", 8'h30, 8'h30);
    idle(4);
    step(); expa(4, "cvn.c2", ID_NONE, ID_NONE);
    step(); expa(4, "cvn.c3", ID_NONE, ID_NONE);
    put(4, 8'h31, sb_t'(1), 64'h3000, bv_t'(8'h55));
    step(); expd(4, "cvn.data30", 8'h30, wd30);
    step(); expa(4, "cvn.ack31", 8'h31, 8'h31);
    idle(4);
    step(); expa(4, "cvn.c6", ID_NONE, ID_NONE);
    step(); expa(4, "cvn.c7", ID_NONE, ID_NONE);
    step(); expd(4, "cvn.data31", 8'h31, merge(wd30, sb_t'(1), bv_t'(8'h55)));

    // Write then read same block, lat=3
    wd40 = rnd_blk();
    put(3, 8'h40, '1, 64'h4000, wd40);
    step(); expa(3, "wr.ack40", 8'h40, 8'h40);
    idle(3);
    step(); expa(3, "wr.c2", ID_NONE, ID_NONE);
    step(); expd(3, "wr.data40", 8'h40, wd40);
    st41 = sb_t'($urandom()) | sb_t'(1);
    wd41 = rnd_blk();
    ex   = merge(wd40, st41, wd41);
    put(3, 8'h41, st41, 64'h4000, wd41);
    step(); expa(3, "wr.ack41", 8'h41, 8'h41);
    put(3, 8'h42, '0, 64'h4000, '0);
    step(); expa(3, "wr.ack42", 8'h42, 8'h42);
    idle(3);
    step(); expd(3, "wr.data41", 8'h41, ex);
    step(); expd(3, "wr.data42", 8'h42, ex);

    // Back-to-back fill, full queue, in-order completion, lat=8 qsz=4
    for (int k = 0; k < 5; k++) wb[k] = rnd_blk();
    for (int k = 0; k < 4; k++) begin
      put(8, id_t'(8'h21 + k), '1, 64'h5000 + 64'(k * BLK), wb[k]);
      step(); expa(8, "b2b.ack", id_t'(8'h21 + k), id_t'(8'h21 + k));
    end
    put(8, 8'h25, '1, 64'h5000 + 64'(4 * BLK), wb[4]);
    for (int c = 0; c < 3; c++) begin
      step(); expa(8, "b2b.full", ID_NONE, ID_NONE);
    end
    for (int k = 0; k < 4; k++) begin
      step(); expd(8, "b2b.done", id_t'(8'h21 + k), wb[k]);
    end
    step(); expa(8, "b2b.ack25", 8'h25, 8'h25);
    idle(8);
    for (int c = 0; c < 6; c++) begin
      step(); expa(8, "b2b.wait25", ID_NONE, ID_NONE);
    end
    step(); expd(8, "b2b.data25", 8'h25, wb[4]);

    // Reset with three entries pending, lat=4
    for (int k = 0; k < 3; k++) begin
      wb[k] = rnd_blk();
      put(4, id_t'(8'h51 + k), '1, 64'h6000 + 64'(k * BLK), wb[k]);
      step(); expa(4, "mrst.ack", id_t'(8'h51 + k), id_t'(8'h51 + k));
    end
    rst = 1'b1;
    idle(4);
    step(); expd(4, "mrst.out0", ID_NONE, '0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(); expa(4, "mrst.none", ID_NONE, ID_NONE);
    end
    put(4, 8'h54, '0, 64'h6000 + 64'(BLK), '0);
    step(); expa(4, "mrst.ack54", 8'h54, 8'h54);
    idle(4);
    step(); expa(4, "mrst.c2", ID_NONE, ID_NONE);
    step(); expa(4, "mrst.c3", ID_NONE, ID_NONE);
    step(); expd(4, "mrst.data54", 8'h54, wb[1]);

    // Randomized traffic against the transaction model
    rnd(8, 8, 40);
    rnd(3, 3, 40);
    rnd(4, 4, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
